// File: rtl/lz77_stream_encoder.sv
// LZ77 stream encoder: fills a look-ahead window, scans the search buffer one offset per
// cycle, emits (offset, match_len, char_nxt) tokens and slides the matched characters into history.
module lz77_stream_encoder #(
    parameter int SEARCH_LEN    = 11,
    parameter int LOOKAHEAD_LEN = 5,
    parameter int CHAR_W        = 4,
    parameter int OFFSET_W      = $clog2(SEARCH_LEN),
    parameter int LEN_W         = $clog2(LOOKAHEAD_LEN)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [7:0]          in_data,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OFFSET_W-1:0] offset,
    output logic [LEN_W-1:0]    match_len,
    output logic [7:0]          char_nxt,
    output logic                encode,
    output logic                finish
);
    typedef enum logic [2:0] {IDLE, FILL, SEARCH, OUT, SHIFT, DONE} state_t;
    typedef logic [LEN_W:0]      la_cnt_t;
    typedef logic [OFFSET_W:0]   sb_cnt_t;
    typedef logic [OFFSET_W-1:0] off_t;

    state_t              state, state_nxt;
    logic [CHAR_W-1:0]   la_q [LOOKAHEAD_LEN];
    logic [CHAR_W-1:0]   sb_q [SEARCH_LEN];
    la_cnt_t             la_count, best_len, cand_len, fin_len, cap, shift_rem;
    sb_cnt_t             search_count;
    off_t                cand, best_off, fin_off;
    logic                last_seen, term_q, take, cand_better, fin_term, run;
    logic [CHAR_W-1:0]   ref_c, fin_chr;
    logic                unused_data;

    assign take        = in_valid && in_ready;
    assign in_ready    = (state == FILL) && !last_seen;
    assign out_valid   = (state == OUT);
    assign finish      = (state == DONE);
    assign encode      = 1'b1;
    assign unused_data = ^in_data;

    // Before the stream end is seen one look-ahead slot stays reserved for char_nxt.
    always_comb begin
        cap = la_cnt_t'(LOOKAHEAD_LEN - 1);
        if (last_seen) begin
            if (la_count < cap) cap = la_count;
        end else if (la_count == '0) begin
            cap = '0;
        end else if (la_count - la_cnt_t'(1) < cap) begin
            cap = la_count - la_cnt_t'(1);
        end
    end

    // Match length for the current candidate; the reference walks out of the search
    // buffer into the look-ahead itself, so runs may overlap the text being encoded.
    always_comb begin
        cand_len = '0;
        ref_c    = '0;
        run      = {1'b0, cand} < search_count;
        for (int j = 0; j < LOOKAHEAD_LEN - 1; j++) begin
            ref_c = '0;
            for (int k = 0; k < SEARCH_LEN; k++)
                if (j <= int'(cand) && int'(cand) - j == k) ref_c = sb_q[k];
            for (int k = 0; k < LOOKAHEAD_LEN; k++)
                if (j > int'(cand) && j - int'(cand) - 1 == k) ref_c = la_q[k];
            run = run && (la_cnt_t'(j) < cap) && (ref_c == la_q[j]);
            if (run) cand_len = cand_len + la_cnt_t'(1);
        end
    end

    assign cand_better = cand_len > best_len;
    assign fin_len     = cand_better ? cand_len : best_len;
    assign fin_off     = cand_better ? cand : best_off;
    assign fin_term    = last_seen && (fin_len == la_count);

    always_comb begin
        fin_chr = '0;
        for (int i = 0; i < LOOKAHEAD_LEN; i++)
            if (la_cnt_t'(i) == fin_len) fin_chr = la_q[i];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   state_nxt = FILL;
            FILL:   if (take && (in_last || la_count == la_cnt_t'(LOOKAHEAD_LEN - 1)))
                        state_nxt = SEARCH;
            SEARCH: if (cand == '0) state_nxt = OUT;
            OUT:    if (out_ready) state_nxt = SHIFT;
            SHIFT:  if (shift_rem <= la_cnt_t'(1))
                        state_nxt = term_q ? DONE : (last_seen ? SEARCH : FILL);
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LOOKAHEAD_LEN; i++) la_q[i] <= '0;
            for (int k = 0; k < SEARCH_LEN; k++)    sb_q[k] <= '0;
            la_count     <= '0;
            search_count <= '0;
            last_seen    <= 1'b0;
            cand         <= '0;
            best_len     <= '0;
            best_off     <= '0;
            term_q       <= 1'b0;
            shift_rem    <= '0;
            offset       <= '0;
            match_len    <= '0;
            char_nxt     <= 8'h00;
        end else begin
            case (state)
                FILL: if (take) begin
                    for (int i = 0; i < LOOKAHEAD_LEN; i++)
                        if (la_cnt_t'(i) == la_count) la_q[i] <= in_data[CHAR_W-1:0];
                    la_count <= la_count + la_cnt_t'(1);
                    if (in_last) last_seen <= 1'b1;
                end
                SEARCH: begin
                    best_len <= fin_len;
                    best_off <= fin_off;
                    cand     <= cand - off_t'(1);
                    if (cand == '0) begin
                        offset    <= fin_off;
                        match_len <= fin_len[LEN_W-1:0];
                        char_nxt  <= fin_term ? 8'h24 : 8'(fin_chr);
                        term_q    <= fin_term;
                    end
                end
                OUT: if (out_ready)
                    shift_rem <= term_q ? {1'b0, match_len} : {1'b0, match_len} + la_cnt_t'(1);
                SHIFT: if (shift_rem != '0) begin
                    sb_q[0] <= la_q[0];
                    for (int k = 1; k < SEARCH_LEN; k++) sb_q[k] <= sb_q[k-1];
                    for (int i = 0; i < LOOKAHEAD_LEN - 1; i++) la_q[i] <= la_q[i+1];
                    la_q[LOOKAHEAD_LEN-1] <= '0;
                    la_count  <= la_count - la_cnt_t'(1);
                    shift_rem <= shift_rem - la_cnt_t'(1);
                    if (search_count != sb_cnt_t'(SEARCH_LEN))
                        search_count <= search_count + sb_cnt_t'(1);
                end
                DONE: begin
                    for (int i = 0; i < LOOKAHEAD_LEN; i++) la_q[i] <= '0;
                    for (int k = 0; k < SEARCH_LEN; k++)    sb_q[k] <= '0;
                    la_count     <= '0;
                    search_count <= '0;
                    last_seen    <= 1'b0;
                    term_q       <= 1'b0;
                end
                default: ;
            endcase
            if (state_nxt == SEARCH && state != SEARCH) begin
                cand     <= off_t'(SEARCH_LEN - 1);
                best_len <= '0;
                best_off <= '0;
            end
        end
    end
endmodule

// File: tb/tb_lz77_stream_encoder.sv
// Bench for lz77_stream_encoder: a string-level LZ77 model predicts every token, directed
// streams pin exact tokens, and a small-window instance is round-tripped through a decoder.
module tb_lz77_stream_encoder;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready;
    logic [7:0] a_in_data, a_char_nxt;
    logic [3:0] a_offset;
    logic [2:0] a_match_len;
    logic       a_encode, a_finish;

    logic       b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready;
    logic [7:0] b_in_data, b_char_nxt;
    logic [1:0] b_offset;
    logic [1:0] b_match_len;
    logic       b_encode, b_finish;

    lz77_stream_encoder dut_a (
        .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_last(a_in_last), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .offset(a_offset), .match_len(a_match_len),
        .char_nxt(a_char_nxt), .encode(a_encode), .finish(a_finish));

    lz77_stream_encoder #(.SEARCH_LEN(4), .LOOKAHEAD_LEN(3), .CHAR_W(4)) dut_b (
        .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_last(b_in_last), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .offset(b_offset), .match_len(b_match_len),
        .char_nxt(b_char_nxt), .encode(b_encode), .finish(b_finish));

    typedef struct {int off; int len; int chr;} tok_t;
    tok_t expA[$], expB[$], gotA[$], gotB[$];
    tok_t ce, cg;
    int   stim[$];
    int   total = 0, bad = 0, finA = 0, finB = 0;

    function automatic void chk(input string nm, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endfunction

    // Greedy LZ77 over the whole string: history is the last sl characters, at most ll-1
    // characters matched, and never more than remain; ties go to the farthest offset.
    function automatic void model(input int sl, input int ll, input bit to_b);
        int n, p, rem, cap, hist, l;
        bit term;
        tok_t t;
        n = stim.size(); p = 0; term = 0;
        while (!term) begin
            rem  = n - p;
            cap  = (rem < ll - 1) ? rem : ll - 1;
            hist = (p < sl) ? p : sl;
            t.off = 0; t.len = 0; t.chr = 0;
            for (int o = hist - 1; o >= 0; o--) begin
                l = 0;
                while (l < cap && stim[p + l] == stim[p - 1 - o + l]) l++;
                if (l > t.len) begin t.len = l; t.off = o; end
            end
            if (t.len == rem) begin t.chr = 'h24; term = 1; end
            else t.chr = stim[p + t.len];
            p = p + t.len + (term ? 0 : 1);
            if (to_b) expB.push_back(t); else expA.push_back(t);
        end
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            if (a_out_valid && a_out_ready) begin
                cg.off = int'(a_offset); cg.len = int'(a_match_len); cg.chr = int'(a_char_nxt);
                gotA.push_back(cg);
                if (expA.size() == 0) chk("A unexpected token", 1, 0);
                else begin
                    ce = expA.pop_front();
                    chk("A offset", cg.off, ce.off);
                    chk("A match_len", cg.len, ce.len);
                    chk("A char_nxt", cg.chr, ce.chr);
                end
            end
            if (b_out_valid && b_out_ready) begin
                cg.off = int'(b_offset); cg.len = int'(b_match_len); cg.chr = int'(b_char_nxt);
                gotB.push_back(cg);
                if (expB.size() == 0) chk("B unexpected token", 1, 0);
                else begin
                    ce = expB.pop_front();
                    chk("B offset", cg.off, ce.off);
                    chk("B match_len", cg.len, ce.len);
                    chk("B char_nxt", cg.chr, ce.chr);
                end
            end
            if (a_finish) finA++;
            if (b_finish) finB++;
        end
    end

    task automatic send(input bit wb);
        int t;
        for (int i = 0; i < stim.size(); i++) begin
            if (wb) begin
                b_in_valid = 1; b_in_data = 8'(stim[i]); b_in_last = (i == stim.size() - 1);
            end else begin
                a_in_valid = 1; a_in_data = 8'(stim[i]); a_in_last = (i == stim.size() - 1);
            end
            t = 0;
            while (!(wb ? b_in_ready : a_in_ready) && t < 300) begin @(negedge clk); t++; end
            if (!(wb ? b_in_ready : a_in_ready)) begin chk("in_ready timeout", 0, 1); break; end
            @(negedge clk);
        end
        a_in_valid = 0; a_in_last = 0; b_in_valid = 0; b_in_last = 0;
    endtask

    task automatic wait_done(input bit wb, input int fin0);
        int t;
        t = 0;
        while ((wb ? finB : finA) == fin0 && t < 600) begin @(negedge clk); t++; end
        chk("finish seen", (wb ? finB : finA) - fin0, 1);
        repeat (3) @(negedge clk);
        chk("finish single pulse", (wb ? finB : finA) - fin0, 1);
        chk("tokens outstanding", wb ? expB.size() : expA.size(), 0);
    endtask

    task automatic run_a();
        int fin0;
        gotA.delete(); expA.delete();
        model(11, 5, 0);
        fin0 = finA;
        send(0);
        wait_done(0, fin0);
    endtask

    task automatic chk_tok(input string nm, input int idx, input int off, input int len, input int chr);
        if (idx >= gotA.size()) chk({nm, " missing"}, gotA.size(), idx + 1);
        else begin
            chk({nm, " off"}, gotA[idx].off, off);
            chk({nm, " len"}, gotA[idx].len, len);
            chk({nm, " chr"}, gotA[idx].chr, chr);
        end
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, " in_ready"}, a_in_ready, 0);
        chk({nm, " out_valid"}, a_out_valid, 0);
        chk({nm, " finish"}, a_finish, 0);
        chk({nm, " offset"}, a_offset, 0);
        chk({nm, " match_len"}, a_match_len, 0);
        chk({nm, " char_nxt"}, a_char_nxt, 0);
    endtask

    initial begin
        int fin0, t, idx;
        int dec[$];
        reset = 0;
        a_in_valid = 0; a_in_data = 0; a_in_last = 0; a_out_ready = 1;
        b_in_valid = 0; b_in_data = 0; b_in_last = 0; b_out_ready = 1;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        chk("encode A", a_encode, 1);
        chk("encode B", b_encode, 1);
        reset = 1;
        @(negedge clk);

        // 1,1,1,1,1,1: overlapping run of four then terminator
        stim = '{1, 1, 1, 1, 1, 1};
        expA.delete(); model(11, 5, 0);
        chk("model38 count", expA.size(), 3);
        if (expA.size() > 1) chk("model38 len", expA[1].len, 4);
        run_a();
        chk("r38 count", gotA.size(), 3);
        chk_tok("r38 t0", 0, 0, 0, 1);
        chk_tok("r38 t1", 1, 0, 4, 1);
        chk_tok("r38 t2", 2, 0, 0, 'h24);

        stim = '{1, 2, 3, 1, 2, 3, 4};
        run_a();
        chk("r39 count", gotA.size(), 5);
        chk_tok("r39 t2", 2, 0, 0, 3);
        chk_tok("r39 t3", 3, 2, 3, 4);
        chk_tok("r39 t4", 4, 0, 0, 'h24);

        stim = '{7};
        run_a();
        chk("r41 count", gotA.size(), 2);
        chk_tok("r41 t0", 0, 0, 0, 7);
        chk_tok("r41 t1", 1, 0, 0, 'h24);

        // terminator that itself carries a match
        stim = '{1, 1, 1};
        run_a();
        chk("rmt count", gotA.size(), 2);
        chk_tok("rmt t1", 1, 0, 2, 'h24);

        // downstream stall on the first token
        stim = '{1, 1, 1, 1, 1, 1};
        gotA.delete(); expA.delete(); model(11, 5, 0);
        fin0 = finA;
        a_out_ready = 0;
        fork
            send(0);
            begin
                t = 0;
                while (!a_out_valid && t < 300) begin @(negedge clk); t++; end
                chk("stall valid seen", a_out_valid, 1);
                repeat (20) begin
                    @(negedge clk);
                    chk("stall out_valid", a_out_valid, 1);
                    chk("stall offset", a_offset, 0);
                    chk("stall match_len", a_match_len, 0);
                    chk("stall char_nxt", a_char_nxt, 1);
                    chk("stall in_ready", a_in_ready, 0);
                end
                @(posedge clk); #1 a_out_ready = 1;
            end
        join
        wait_done(0, fin0);
        chk("r40 count", gotA.size(), 3);
        chk_tok("r40 t1", 1, 0, 4, 1);

        // reset while the second token is being searched
        stim = '{1, 2, 3, 4, 5, 6};
        gotA.delete(); expA.delete(); model(11, 5, 0);
        send(0);
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        chk_reset_vals("midreset");
        chk("midreset tokens before", gotA.size(), 1);
        expA.delete();
        reset = 1;
        repeat (30) @(negedge clk);
        stim = '{1, 2};
        run_a();
        chk("r42 count", gotA.size(), 3);
        chk_tok("r42 t0", 0, 0, 0, 1);
        chk_tok("r42 t1", 1, 0, 0, 2);
        chk_tok("r42 t2", 2, 0, 0, 'h24);

        // small window, random stream, decoded back
        stim.delete();
        for (int i = 0; i < 20; i++) stim.push_back(int'($urandom_range(0, 3)));
        gotB.delete(); expB.delete(); model(4, 3, 1);
        fin0 = finB;
        send(1);
        wait_done(1, fin0);
        dec.delete();
        foreach (gotB[k]) begin
            chk("B offset range", int'(gotB[k].off < 4), 1);
            chk("B len range", int'(gotB[k].len <= 2), 1);
            for (int j = 0; j < gotB[k].len; j++) begin
                idx = dec.size() - 1 - gotB[k].off;
                if (idx >= 0) dec.push_back(dec[idx]);
                else begin chk("B decode back-ref", idx, 0); dec.push_back(-1); end
            end
            if (gotB[k].chr != 'h24) dec.push_back(gotB[k].chr);
        end
        chk("B decoded length", dec.size(), 20);
        for (int i = 0; i < 20 && i < dec.size(); i++) chk("B decoded char", dec[i], stim[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
        $fatal(1);
    end
endmodule

// File: doc/lz77_stream_encoder.md
LZ77_STREAM_ENCODER -- requirements
Module: lz77_stream_encoder

Interface
REQ-001 SHALL provide parameter SEARCH_LEN, default 11, search-buffer depth in characters (2..15).
REQ-002 SHALL provide parameter LOOKAHEAD_LEN, default 5, look-ahead depth in characters (2..8); maximum match_len is LOOKAHEAD_LEN-1.
REQ-003 SHALL provide parameter CHAR_W, default 4, stored character width in bits (1..8).
REQ-004 SHALL provide parameters OFFSET_W = clog2(SEARCH_LEN) and LEN_W = clog2(LOOKAHEAD_LEN), derived, not overridden.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 in_valid  input  1  in_data/in_last valid this cycle.
REQ-008 in_ready  output  1  encoder accepts a character this cycle.
REQ-009 in_data  input  8  character; only bits [CHAR_W-1:0] are stored.
REQ-010 in_last  input  1  qualifies the final character of the stream.
REQ-011 out_valid  output  1  token fields valid.
REQ-012 out_ready  input  1  downstream accepts the token.
REQ-013 offset  output  OFFSET_W  match distance; 0 = most recent search-buffer character.
REQ-014 match_len  output  LEN_W  number of matched characters.
REQ-015 char_nxt  output  8  next character, zero-extended, or 8'h24 terminator.
REQ-016 encode  output  1  tied to 1.
REQ-017 finish  output  1  one-cycle pulse at end of stream.

Function
REQ-018 SHALL implement states IDLE, FILL, SEARCH, OUT, SHIFT and DONE; reset enters IDLE, and IDLE goes to FILL the next cycle.
REQ-019 FILL SHALL assert in_ready and append one character per in_valid&in_ready handshake at lookahead[la_count].
REQ-020 FILL SHALL leave for SEARCH when la_count==LOOKAHEAD_LEN, or when last_seen is set (in_last accepted, sticky).
REQ-021 in_ready SHALL be 0 in every state except FILL, and SHALL be 0 in FILL once last_seen is set.
REQ-022 SEARCH SHALL evaluate one candidate offset per cycle, from SEARCH_LEN-1 down to 0, always spending exactly SEARCH_LEN cycles.
REQ-023 A candidate offset o SHALL be legal only when o < search_count; illegal candidates yield length 0.
REQ-024 A match at offset o compares position j against search[o-j] for j<=o, else lookahead[j-o-1]; overlapping into the look-ahead is permitted.
REQ-025 Candidate length SHALL be the count of consecutive equal positions from j=0, capped at cap.
REQ-026 cap SHALL equal min(LOOKAHEAD_LEN-1, la_count-1) when last_seen is 0, and min(LOOKAHEAD_LEN-1, la_count) when last_seen is 1.
REQ-027 The best candidate SHALL replace the held token only when strictly longer; ties therefore keep the larger offset.
REQ-028 With no match, offset SHALL be 0 and match_len SHALL be 0.
REQ-029 char_nxt SHALL be 8'h24 when last_seen==1 and match_len==la_count (includes la_count==0); otherwise lookahead[match_len] zero-extended.
REQ-030 OUT SHALL hold out_valid=1 with offset, match_len and char_nxt stable until out_ready=1, then go to SHIFT.
REQ-031 SHIFT SHALL move one character per cycle from lookahead[0] into search[0], ageing search[k] to search[k+1] and dropping search[SEARCH_LEN-1].
REQ-032 SHIFT SHALL move match_len+1 characters, or match_len if the terminator was sent; la_count decrements and search_count saturates at SEARCH_LEN.
REQ-033 After SHIFT, the next state SHALL be DONE if the terminator was sent, SEARCH if last_seen is set, else FILL.
REQ-034 DONE SHALL pulse finish=1 for one cycle, then return to IDLE with la_count, search_count and last_seen cleared.
REQ-035 An in_last accepted on the first character SHALL still produce the token (0,0,char) followed by the token (0,0,8'h24).

Reset
REQ-036 While reset=0, in any state, SHALL force state IDLE, in_ready=0, out_valid=0, finish=0, offset=0, match_len=0, char_nxt=8'h00, counters 0, last_seen=0 and buffers cleared to 0.
REQ-037 A token pending in OUT at reset SHALL be discarded, never re-presented.

Verification
REQ-038 Stream 1,1,1,1,1,1 (in_last on the 6th), out_ready=1 -> tokens (0,0,1), (0,4,1), (0,0,8'h24), then a finish pulse.
REQ-039 Stream 1,2,3,1,2,3,4 (last on 4) -> tokens (0,0,1), (0,0,2), (0,0,3), (2,3,4), (0,0,8'h24).
REQ-040 Same stream as REQ-038 with out_ready held 0 for 20 cycles -> out_valid stays 1, fields unchanged, in_ready 0, no character loss.
REQ-041 Single character 7 with in_last -> tokens (0,0,7), (0,0,8'h24), then finish.
REQ-042 Reset driven low during SEARCH of the second token -> all outputs at reset values next cycle; a new stream encodes from empty history.
REQ-043 SEARCH_LEN=4, LOOKAHEAD_LEN=3 and a 20-character random stream -> decoded tokens reproduce the stream, every offset < 4 and every match_len <= 2.
